ic_cache_nway: RTL and testbench

Parametrised N-way set-associative instruction cache, the successor of the direct-mapped `ic_dram`. It sits between `instruction_get` (cpu port) and `m_axi4_read_top` (dma port), and is pin-compatible with `ic_dram` on both ports. Over `ic_dram` it adds:
- configurable associativity with round-robin replacement;
- flush plus first-line prefetch on `start`;
- hit/miss statistics counters.

---
 rtl/ic_cache_nway.sv | 165 ++++++++++++++++
 tb/tb_ic_cache_nway.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ic_cache_nway.sv
// ic_cache_nway: N-way set-associative instruction cache with round-robin replacement,
// flush/prefetch on start and saturating hit/miss counters.
module ic_cache_nway #(
  parameter int WAYS   = 2,
  parameter int SET_AW = 9,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic              cpu_read_valid,
  input  logic [ADDR_W-1:0] cpu_read_addr,
  output logic [DATA_W-1:0] ic_data,
  output logic              cpu_read_ack,
  output logic              ic_read_dma_valid,
  output logic [ADDR_W-1:0] ic_read_dma_addr,
  input  logic              ic_read_dma_ack,
  input  logic [DATA_W-1:0] ic_read_dma_data,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int TAG_W = LINE_W - SET_AW;
  localparam int SETS = 1 << SET_AW;
  localparam int PTR_W = WAYS > 1 ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESP, PREFETCH} state_t;

  state_t              state_q, state_d;
  logic                en_q, en_d, pend_q, pend_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [31:0]         hit_q, hit_d, miss_q, miss_d;
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     valid_d [SETS];
  logic [PTR_W-1:0]    ptr_q [SETS];
  logic [PTR_W-1:0]    ptr_d [SETS];
  logic [DATA_W-1:0]   sel_data [WAYS];
  logic [WAYS-1:0]     hit_vec, we;
  logic [DATA_W-1:0]   hit_data;
  logic [PTR_W-1:0]    victim;
  logic [SET_AW-1:0]   idx, rd_idx;
  logic [TAG_W-1:0]    tag;
  logic                fill, unused_bits;

  assign idx = line_q[SET_AW-1:0];
  assign tag = line_q[LINE_W-1:SET_AW];
  assign rd_idx = cpu_read_addr[OFF_W +: SET_AW];
  assign fill = (state_q == REFILL || state_q == PREFETCH) && ic_read_dma_ack;
  assign unused_bits = ^{cpu_read_addr[OFF_W-1:0], first_addr[OFF_W-1:0]};

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W-1:0]  tag_mem [SETS];
    logic [DATA_W-1:0] data_mem [SETS];
    logic [TAG_W-1:0]  tag_rd;
    logic [DATA_W-1:0] data_rd;
    assign we[w] = fill && victim == PTR_W'(w);
    assign hit_vec[w] = valid_q[idx][w] && tag_rd == tag;
    assign sel_data[w] = hit_vec[w] ? data_rd : '0;
    always_ff @(posedge clk) begin
      if (we[w]) begin
        tag_mem[idx] <= tag;
        data_mem[idx] <= ic_read_dma_data;
      end
      tag_rd <= tag_mem[rd_idx];
      data_rd <= data_mem[rd_idx];
    end
  end

  // lowest invalid way wins; a full set falls back to its round-robin pointer
  always_comb begin
    victim = ptr_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) if (!valid_q[idx][w]) victim = PTR_W'(w);
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) hit_data = hit_data | sel_data[w];
  end

  always_comb begin
    state_d = state_q;
    en_d = en_q;
    pend_d = pend_q;
    line_d = line_q;
    data_d = data_q;
    hit_d = hit_q;
    miss_d = miss_q;
    valid_d = valid_q;
    ptr_d = ptr_q;
    if (fill) begin
      valid_d[idx][victim] = 1'b1;
      if (&valid_q[idx]) ptr_d[idx] = victim == PTR_W'(WAYS - 1) ? '0 : victim + 1'b1;
    end
    case (state_q)
      IDLE:
        if (!stop && (pend_q || start)) begin
          en_d = 1'b1;
          pend_d = 1'b0;
          hit_d = '0;
          miss_d = '0;
          line_d = first_addr[ADDR_W-1:OFF_W];
          for (int s = 0; s < SETS; s++) valid_d[s] = '0;
          state_d = PREFETCH;
        end else if (en_q && !stop && cpu_read_valid) begin
          line_d = cpu_read_addr[ADDR_W-1:OFF_W];
          state_d = LOOKUP;
        end
      LOOKUP:
        if (|hit_vec) begin
          data_d = hit_data;
          hit_d = hit_q + {31'b0, ~&hit_q};
          state_d = RESP;
        end else begin
          miss_d = miss_q + {31'b0, ~&miss_q};
          state_d = REFILL;
        end
      REFILL:
        if (ic_read_dma_ack) begin
          data_d = ic_read_dma_data;
          state_d = RESP;
        end
      RESP: state_d = IDLE;
      PREFETCH: state_d = ic_read_dma_ack ? IDLE : PREFETCH;
      default: state_d = IDLE;
    endcase
    if (start && state_q != IDLE) pend_d = 1'b1;
    if (stop) begin
      en_d = 1'b0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q <= 1'b0;
      pend_q <= 1'b0;
      line_q <= '0;
      data_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
      valid_q <= '{default: '0};
      ptr_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      pend_q <= pend_d;
      line_q <= line_d;
      data_q <= data_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
      valid_q <= valid_d;
      ptr_q <= ptr_d;
    end
  end

  assign ic_data = data_q;
  assign cpu_read_ack = state_q == RESP && en_q && !stop;
  assign ic_read_dma_valid = state_q == REFILL || state_q == PREFETCH;
  assign ic_read_dma_addr = ic_read_dma_valid ? {line_q, OFF_W'(0)} : '0;
  assign hit_cnt = hit_q;
  assign miss_cnt = miss_q;
endmodule

// File: tb/tb_ic_cache_nway.sv
// tb_ic_cache_nway: directed bench for a 2-way and a direct-mapped cache instance,
// with a bench-driven DMA responder of programmable latency.
module tb_ic_cache_nway;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  logic         start [2], stop [2], cpu_valid [2], ack [2], dma_valid [2], dma_ack [2];
  logic [31:0]  first_addr [2], cpu_addr [2], dma_addr [2], hit [2], miss [2];
  logic [127:0] ic_data [2], dma_data [2];
  int           n_chk = 0, n_fail = 0;
  int           dly [2], dma_cnt [2], vh [2], wait_c [2];
  logic [31:0]  dma_last [2];
  logic [127:0] pat;

  ic_cache_nway #(.WAYS(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .stop(stop[0]), .first_addr(first_addr[0]),
    .cpu_read_valid(cpu_valid[0]), .cpu_read_addr(cpu_addr[0]), .ic_data(ic_data[0]),
    .cpu_read_ack(ack[0]), .ic_read_dma_valid(dma_valid[0]), .ic_read_dma_addr(dma_addr[0]),
    .ic_read_dma_ack(dma_ack[0]), .ic_read_dma_data(dma_data[0]), .hit_cnt(hit[0]), .miss_cnt(miss[0])
  );

  ic_cache_nway #(.WAYS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .stop(stop[1]), .first_addr(first_addr[1]),
    .cpu_read_valid(cpu_valid[1]), .cpu_read_addr(cpu_addr[1]), .ic_data(ic_data[1]),
    .cpu_read_ack(ack[1]), .ic_read_dma_valid(dma_valid[1]), .ic_read_dma_addr(dma_addr[1]),
    .ic_read_dma_ack(dma_ack[1]), .ic_read_dma_data(dma_data[1]), .hit_cnt(hit[1]), .miss_cnt(miss[1])
  );

  function automatic logic [127:0] fp(input logic [31:0] a);
    logic [31:0] la;
    la = a & ~32'hF;
    return {la, ~la, la ^ 32'h5A5A_5A5A, 32'hC0DE_0000 + la};
  endfunction

  // DMA slave: acks after dly[i] extra cycles of valid, one-cycle ack pulse
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (dma_valid[i]) vh[i]++;
      if (dma_ack[i]) dma_ack[i] = 0;
      else if (dma_valid[i]) begin
        if (wait_c[i] >= dly[i]) begin
          dma_ack[i] = 1;
          dma_data[i] = pat;
          dma_cnt[i]++;
          dma_last[i] = dma_addr[i];
          wait_c[i] = 0;
        end else wait_c[i]++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int i, input logic [31:0] a, input int lim, output int lat, output logic [127:0] d);
    @(negedge clk);
    cpu_valid[i] = 1;
    cpu_addr[i] = a;
    lat = -1;
    d = '0;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (ack[i]) begin
        lat = k;
        d = ic_data[i];
        break;
      end
    end
    cpu_valid[i] = 0;
  endtask

  task automatic acc(input int i, input logic [31:0] a, input bit exp_hit, input logic [127:0] dd, input string tag);
    int lat;
    logic [127:0] d;
    int c0;
    c0 = dma_cnt[i];
    pat = dd;
    rd(i, a, 60, lat, d);
    chk({tag, " latency"}, lat, exp_hit ? 2 : dly[i] + 3);
    chk({tag, " data"}, d, dd);
    chk({tag, " dma count"}, dma_cnt[i] - c0, exp_hit ? 0 : 1);
    if (!exp_hit) chk({tag, " dma addr"}, dma_last[i], a & ~32'hF);
  endtask

  task automatic st(input int i, input logic [31:0] fa, input string tag);
    int c0;
    bit seen;
    c0 = dma_cnt[i];
    seen = 0;
    pat = fp(fa);
    @(negedge clk);
    start[i] = 1;
    first_addr[i] = fa;
    @(negedge clk);
    start[i] = 0;
    chk({tag, " prefetch valid"}, dma_valid[i], 1);
    chk({tag, " prefetch addr"}, dma_addr[i], fa & ~32'hF);
    chk({tag, " hit cleared"}, hit[i], 0);
    chk({tag, " miss cleared"}, miss[i], 0);
    for (int k = 0; k < 60 && dma_valid[i]; k++) begin
      @(negedge clk);
      seen |= ack[i];
    end
    chk({tag, " prefetch done"}, dma_cnt[i] - c0, 1);
    chk({tag, " prefetch no ack"}, seen, 0);
  endtask

  initial begin
    int lat;
    logic [127:0] d;
    int c0;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; stop[i] = 0; cpu_valid[i] = 0; cpu_addr[i] = 0;
      first_addr[i] = 0; dma_ack[i] = 0; dma_data[i] = 0; dly[i] = 0;
    end
    pat = '0;
    repeat (3) @(negedge clk);
    chk("reset ack", ack[0], 0);
    chk("reset dma valid", dma_valid[0], 0);
    chk("reset dma addr", dma_addr[0], 0);
    chk("reset data", ic_data[0], 0);
    chk("reset hit", hit[0], 0);
    chk("reset miss", miss[0], 0);
    rst_n = 1;

    rd(0, 32'h100, 5, lat, d);
    chk("disabled ignore", lat, -1);
    chk("disabled no dma", dma_cnt[0], 0);

    st(0, 32'h100, "start");
    acc(0, 32'h104, 1, fp(32'h100), "prefetched hit");
    chk("first hit cnt", hit[0], 1);
    chk("first miss cnt", miss[0], 0);

    acc(0, 32'h0000, 0, fp(32'h0000), "miss 0000");
    acc(0, 32'h2000, 0, fp(32'h2000), "miss 2000");
    acc(0, 32'h0000, 1, fp(32'h0000), "hit 0000");
    acc(0, 32'h4000, 0, fp(32'h4000), "evict way0");
    acc(0, 32'h2000, 1, fp(32'h2000), "way1 kept");
    acc(0, 32'h0000, 0, fp(32'h0000), "evicted miss");
    acc(0, 32'h4000, 1, fp(32'h4000), "hit 4000");
    chk("2way hits", hit[0], 4);
    chk("2way misses", miss[0], 4);

    dly[0] = 19;
    vh[0] = 0;
    acc(0, 32'h801C, 0, {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF}, "slow dma");
    chk("slow dma valid cycles", vh[0], 20);

    dly[0] = 10;
    c0 = dma_cnt[0];
    seen = 0;
    pat = fp(32'hC000);
    @(negedge clk);
    cpu_valid[0] = 1;
    cpu_addr[0] = 32'hC000;
    for (int k = 0; k < 20 && !dma_valid[0]; k++) @(negedge clk);
    stop[0] = 1;
    @(negedge clk);
    stop[0] = 0;
    for (int k = 0; k < 60 && dma_valid[0]; k++) begin
      @(negedge clk);
      seen |= ack[0];
    end
    repeat (3) begin
      @(negedge clk);
      seen |= ack[0];
    end
    cpu_valid[0] = 0;
    chk("stop no ack", seen, 0);
    chk("stop dma completes", dma_cnt[0] - c0, 1);
    chk("stop dma addr", dma_last[0], 32'hC000);
    chk("stop miss cnt", miss[0], 6);
    c0 = dma_cnt[0];
    rd(0, 32'h4000, 6, lat, d);
    chk("stopped ignore", lat, -1);
    chk("stopped no dma", dma_cnt[0] - c0, 0);

    dly[0] = 0;
    st(0, 32'h100, "restart");
    acc(0, 32'hC000, 0, fp(32'hC000), "flushed miss");
    chk("restart miss cnt", miss[0], 1);
    chk("restart hit cnt", hit[0], 0);

    c0 = dma_cnt[0];
    @(negedge clk);
    start[0] = 1;
    stop[0] = 1;
    @(negedge clk);
    start[0] = 0;
    stop[0] = 0;
    chk("start+stop no prefetch", dma_valid[0], 0);
    rd(0, 32'hC000, 6, lat, d);
    chk("start+stop disabled", lat, -1);
    chk("start+stop no dma", dma_cnt[0] - c0, 0);
    chk("start+stop miss kept", miss[0], 1);

    st(0, 32'h200, "sat start");
    force dut0.miss_q = 32'hFFFF_FFFF;
    #1;
    release dut0.miss_q;
    acc(0, 32'h6000, 0, fp(32'h6000), "sat miss");
    chk("miss saturates", miss[0], 32'hFFFF_FFFF);

    st(1, 32'h100, "dm start");
    for (int k = 0; k < 4; k++) begin
      acc(1, (k % 2) ? 32'h2000 : 32'h0000, 0, fp((k % 2) ? 32'h2000 : 32'h0000), "dm alternate");
      chk("dm miss cnt", miss[1], 32'(k + 1));
    end
    chk("dm hit cnt", hit[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
